// File: rtl/eeg_window_buffer.sv
// Ping-pong window buffer: fills one bank with 256 EEG samples while the seizure
// core reads the other bank through two independent registered read ports.

module eeg_wb_rd_port #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (rd_en) data_d = rd_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign rd_data = data_q;
endmodule

module eeg_window_buffer #(
  parameter int DATA_WIDTH     = 18,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_valid,
  input  logic [DATA_WIDTH-1:0]     sample_data,
  output logic                      core_start,
  output logic                      core_busy,
  input  logic                      core_done,
  input  logic                      pc_fifo_read,
  input  logic [ADDR_WIDTH-1:0]     pc_fifo_addr,
  output logic [DATA_WIDTH-1:0]     pc_fifo_data,
  input  logic                      dctc_fifo_read,
  input  logic [ADDR_WIDTH-1:0]     dctc_fifo_addr,
  output logic [DATA_WIDTH-1:0]     dctc_fifo_data,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  input  logic                      overflow_clr
);
  localparam int NUM_RD = 2;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH:0]   addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  // Bank select is the MSB of the flat memory index.
  logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     wr_cnt_q, wr_cnt_d;
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic                      wr_full_q, wr_full_d;
  logic                      core_start_q, core_start_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic    release_full, is_last, last_swap, swap, drop;
  wr_req_t wr_req;

  always_comb begin
    release_full = (state_q == BUSY) && core_done && wr_full_q;
    is_last      = sample_valid && !wr_full_q && (wr_cnt_q == LAST);
    last_swap    = is_last && ((state_q == IDLE) || core_done);
    swap         = release_full || last_swap;
    drop         = sample_valid && wr_full_q && !release_full;

    // On a release the pending window becomes readable and this cycle's sample
    // lands at address 0 of the bank the core just gave back.
    wr_req.we   = sample_valid && (release_full || !wr_full_q);
    wr_req.addr = release_full ? {rd_bank_q, {ADDR_WIDTH{1'b0}}}
                               : {wr_bank_q, wr_cnt_q};
    wr_req.data = sample_data;

    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_full_d    = wr_full_q;
    core_start_d = swap;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;

    if (release_full)   wr_cnt_d = sample_valid ? ADDR_WIDTH'(1) : '0;
    else if (wr_req.we) wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);

    if (swap) begin
      wr_bank_d = rd_bank_q;
      rd_bank_d = wr_bank_q;
    end

    if (release_full)                wr_full_d = 1'b0;
    else if (is_last && !last_swap)  wr_full_d = 1'b1;

    if (swap)                            state_d = BUSY;
    else if (state_q == BUSY && core_done) state_d = IDLE;

    if (overflow_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b1;
      wr_full_q    <= 1'b0;
      core_start_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_full_q    <= wr_full_d;
      core_start_q <= core_start_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_req.we) mem[wr_req.addr] <= wr_req.data;
  end

  logic [NUM_RD-1:0]                 rd_en;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_word;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;

  assign rd_en   = {dctc_fifo_read, pc_fifo_read};
  assign rd_addr = {dctc_fifo_addr, pc_fifo_addr};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_word[p] = mem[{rd_bank_q, rd_addr[p]}];
    eeg_wb_rd_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en[p]),
      .rd_word (rd_word[p]),
      .rd_data (rd_data[p])
    );
  end

  assign pc_fifo_data   = rd_data[0];
  assign dctc_fifo_data = rd_data[1];
  assign core_start     = core_start_q;
  assign core_busy      = (state_q == BUSY);
  assign overflow       = overflow_q;
  assign drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_eeg_window_buffer.sv
// Directed bench for eeg_window_buffer: fill, dual-port reads, overflow,
// coincident release, mid-fill reset, drop-counter saturation.

module tb_eeg_window_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid, core_done, overflow_clr;
  logic [17:0] sample_data;
  logic        pc_rd, dctc_rd;
  logic [7:0]  pc_addr, dctc_addr;
  logic        core_start, core_busy, overflow;
  logic [17:0] pc_data, dctc_data;
  logic [15:0] drop_cnt;

  int n_run = 0;
  int n_fail = 0;
  int starts;

  eeg_window_buffer dut (
    .clk            (clk),
    .reset          (rst),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .core_start     (core_start),
    .core_busy      (core_busy),
    .core_done      (core_done),
    .pc_fifo_read   (pc_rd),
    .pc_fifo_addr   (pc_addr),
    .pc_fifo_data   (pc_data),
    .dctc_fifo_read (dctc_rd),
    .dctc_fifo_addr (dctc_addr),
    .dctc_fifo_data (dctc_data),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt),
    .overflow_clr   (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
    if (core_start) starts++;
  endtask

  task automatic push(input logic [17:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] pa, input logic [7:0] da);
    pc_rd = 1'b1; pc_addr = pa;
    dctc_rd = 1'b1; dctc_addr = da;
    step();
    pc_rd = 1'b0; dctc_rd = 1'b0;
  endtask

  task automatic done_pulse();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 0; sample_data = '0; core_done = 0; overflow_clr = 0;
    pc_rd = 0; dctc_rd = 0; pc_addr = '0; dctc_addr = '0;
    #12;
    chk("rst_start", core_start, 0);
    chk("rst_busy", core_busy, 0);
    chk("rst_pc", pc_data, 0);
    chk("rst_dctc", dctc_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    step();

    // Window 1: samples 1..256
    for (int i = 1; i <= 255; i++) push(18'(i));
    chk("fill_nostart_255", core_start, 0);
    push(18'd256);
    chk("fill_start", core_start, 1);
    chk("fill_busy", core_busy, 1);
    rd(8'd5, 8'd5);
    chk("start_one_cycle", core_start, 0);
    chk("busy_held", core_busy, 1);
    chk("pc_addr5", pc_data, 6);

    rd(8'd0, 8'd255);
    chk("dual_pc0", pc_data, 1);
    chk("dual_dctc255", dctc_data, 256);
    rd(8'd100, 8'd100);
    chk("same_pc", pc_data, 101);
    chk("same_dctc", dctc_data, 101);
    pc_addr = 8'd7; dctc_addr = 8'd8;
    step();
    chk("hold_pc", pc_data, 101);
    chk("hold_dctc", dctc_data, 101);

    // Window 2 completes while busy, then 10 drops
    starts = 0;
    for (int i = 1; i <= 256; i++) push(18'(1000 + i));
    chk("full_no_start", starts, 0);
    chk("full_ovf0", overflow, 0);
    for (int i = 0; i < 10; i++) push(18'd9999);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt10", drop_cnt, 10);
    rd(8'd5, 8'd255);
    chk("ovf_old_pc", pc_data, 6);
    chk("ovf_old_dctc", dctc_data, 256);
    done_pulse();
    chk("release_start", core_start, 1);
    chk("release_busy", core_busy, 1);
    rd(8'd0, 8'd255);
    chk("win2_pc0", pc_data, 1001);
    chk("win2_dctc255", dctc_data, 1256);
    chk("ovf_sticky", overflow, 1);
    overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_cnt", drop_cnt, 0);

    // Window 3: core_done coincides with the last write
    for (int i = 1; i <= 255; i++) push(18'(2000 + i));
    core_done = 1'b1;
    push(18'd2256);
    core_done = 1'b0;
    chk("coin_start", core_start, 1);
    chk("coin_busy", core_busy, 1);
    chk("coin_ovf", overflow, 0);
    chk("coin_drop", drop_cnt, 0);
    rd(8'd0, 8'd255);
    chk("win3_pc0", pc_data, 2001);
    chk("win3_dctc255", dctc_data, 2256);
    done_pulse();
    chk("done_to_idle", core_busy, 0);
    done_pulse();
    chk("done_idle_ignored", core_busy, 0);
    chk("done_idle_nostart", core_start, 0);

    // Reset mid-fill
    for (int i = 1; i <= 100; i++) push(18'(3000 + i));
    rst = 1'b1; #2;
    chk("midrst_busy", core_busy, 0);
    chk("midrst_pc", pc_data, 0);
    rst = 1'b0;
    step();
    starts = 0;
    for (int i = 1; i <= 255; i++) push(18'(4000 + i));
    chk("midrst_nostart", starts, 0);
    push(18'd4256);
    chk("midrst_start", core_start, 1);
    chk("midrst_one_start", starts, 1);
    rd(8'd0, 8'd99);
    chk("midrst_pc0", pc_data, 4001);
    chk("midrst_dctc99", dctc_data, 4100);
    rd(8'd255, 8'd100);
    chk("midrst_pc255", pc_data, 4256);
    chk("midrst_dctc100", dctc_data, 4101);

    // Saturation: fill while busy, then 65540 drops
    for (int i = 1; i <= 256; i++) push(18'(5000 + i));
    sample_valid = 1'b1; sample_data = 18'd1;
    for (int i = 0; i < 65535; i++) step();
    chk("sat_at_max", drop_cnt, 65535);
    for (int i = 0; i < 5; i++) step();
    sample_valid = 1'b0;
    chk("sat_hold", drop_cnt, 65535);
    chk("sat_ovf", overflow, 1);
    overflow_clr = 1'b1;
    push(18'd1);
    overflow_clr = 1'b0;
    chk("clr_prio_ovf", overflow, 0);
    chk("clr_prio_cnt", drop_cnt, 0);

    // Release with a sample in the same cycle: it lands at address 0
    core_done = 1'b1;
    push(18'd77);
    core_done = 1'b0;
    chk("rel_smp_start", core_start, 1);
    chk("rel_smp_drop", drop_cnt, 0);
    rd(8'd0, 8'd255);
    chk("win5_pc0", pc_data, 5001);
    chk("win5_dctc255", dctc_data, 5256);
    for (int i = 78; i <= 332; i++) push(18'(i));
    done_pulse();
    chk("rel2_start", core_start, 1);
    rd(8'd0, 8'd255);
    chk("rel_smp_pc0", pc_data, 77);
    chk("rel_smp_dctc255", dctc_data, 332);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
